// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-side responders (data and, later,
// instruction memory): responder FSM states and the word/byte geometry.
package mips_mem_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage for the data-memory responder.
// Ports:
//   clk    - rising-edge clock
//   wr_en  - write the enabled byte lanes of wdata into word idx
//   rd_en  - register word idx onto rdata
//   idx    - word index (caller guarantees idx < DEPTH_WORDS when enabled)
//   wdata  - store data
//   be     - byte enables, bit i selects wdata[8i+7:8i]
//   rdata  - registered read data
// Contents are deliberately not reset.
module dmem_word_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [IDX_W-1:0]          idx,
  input  logic [WORD_W-1:0]         wdata,
  input  logic [BYTES_PER_WORD-1:0] be,
  output logic [WORD_W-1:0]         rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
        if (be[b]) begin
          mem_q[idx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, then returns a single-cycle response.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   req_valid/req_ready - request handshake (ready only while idle)
//   req_write           - 1 = store, 0 = load
//   req_addr            - byte address (must be word aligned and in range)
//   req_wdata, req_be   - store data and byte enables
//   rsp_valid           - one-cycle response pulse
//   rsp_rdata           - load data with rsp_valid, otherwise 0
//   rsp_err             - misaligned or out-of-range access, with rsp_valid
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [WORD_W-1:0]         req_wdata,
  input  logic [BYTES_PER_WORD-1:0] req_be,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);

  localparam int unsigned        IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]         LAST_WAIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [ADDR_W-2:0]  DEPTH_CMP = (ADDR_W-1)'(DEPTH_WORDS);

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a[ADDR_W-1:2]} >= DEPTH_CMP);
  endfunction

  mem_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      write_q, write_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [WORD_W-1:0]         wdata_q, wdata_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;

  logic                      enter_resp;
  logic                      req_ok;
  logic                      arr_wr_en, arr_rd_en;
  logic [WORD_W-1:0]         arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          cnt_d   = '0;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_WAIT) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // The array is accessed on the edge that enters RESP. Using the *_d capture
  // values covers both paths: from WAIT they equal the held request, and with
  // zero wait states (IDLE -> RESP) they are the live request being accepted.
  // Gating with reset keeps a request presented during reset from writing.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign req_ok     = !addr_err(addr_d);
  assign arr_wr_en  = reset && enter_resp && write_d && req_ok;
  assign arr_rd_en  = reset && enter_resp && !write_d && req_ok;

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .wr_en(arr_wr_en),
    .rd_en(arr_rd_en),
    .idx  (addr_d[IDX_W+1:2]),
    .wdata(wdata_d),
    .be   (be_d),
    .rdata(arr_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && addr_err(addr_q);
  assign rsp_rdata = (rsp_valid && !write_q && !addr_err(addr_q)) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=2 and 0) exercised in
// turn; a per-cycle reference model checks every output of both.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(reset_n[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset_n[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", name, d, $time, act, exp);
    end
  endtask

  task automatic idle_junk(input int d);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
  endtask

  // ---------------- reference model ----------------
  // Per DUT: memory image, one pending request with the cycle its response
  // is due, and the first cycle a new request may be taken.
  logic [31:0] mmem [2][256];
  bit          pv   [2];
  bit          pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  logic [3:0]  pb   [2];
  int unsigned prsp [2];
  int unsigned rdy_at [2];
  int unsigned cyc = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 0; rdy_at[d] = 0; prsp[d] = 0;
    end
  end

  always @(negedge clk) begin : cmp
    logic        ev, ee, er;
    logic [31:0] edata;
    int          idx;
    bit          bad;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      ev = 1'b0; ee = 1'b0; edata = '0; er = 1'b1;
      if (!reset_n[d]) begin
        pv[d]     = 0;
        rdy_at[d] = 0;
      end else begin
        if (pv[d] && cyc == prsp[d]) begin
          bad = (pa[d][1:0] != 2'b00) || ((pa[d] >> 2) >= 256);
          ev  = 1'b1;
          ee  = bad;
          if (!bad) begin
            idx = int'(pa[d] >> 2);
            if (pw[d]) begin
              for (int b = 0; b < 4; b++)
                if (pb[d][b]) mmem[d][idx][8*b +: 8] = pd[d][8*b +: 8];
            end else begin
              edata = mmem[d][idx];
            end
          end
          pv[d] = 0;
        end
        er = (cyc >= rdy_at[d]);
      end
      chk("req_ready", d, 32'(req_ready[d]), 32'(er));
      chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
      chk("rsp_err",   d, 32'(rsp_err[d]),   32'(ee));
      chk("rsp_rdata", d, rsp_rdata[d], edata);
      if (reset_n[d] && req_valid[d] && er) begin
        pv[d]     = 1;
        pw[d]     = req_write[d];
        pa[d]     = req_addr[d];
        pd[d]     = req_wdata[d];
        pb[d]     = req_be[d];
        prsp[d]   = cyc + 1 + ws_of(d);
        rdy_at[d] = cyc + ws_of(d) + 2;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_req(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic e, output int lat);
    bit got;
    rd = '0; e = 1'b0; lat = -1;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[d]) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d got no ready want ready", d);
      idle_junk(d);
      return;
    end
    @(posedge clk); #1;
    idle_junk(d);
    got = 0; lat = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) begin
        got = 1; rd = rsp_rdata[d]; e = rsp_err[d];
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d got no rsp_valid want rsp_valid", d);
    end
  endtask

  task automatic burst(input int d);
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    bit          bw [4];
    logic [31:0] brd [4];
    int n, pulses, last, cycn, gap_bad;
    bit acc;
    ba[0] = 32'h40; ba[1] = 32'h44; ba[2] = 32'h40; ba[3] = 32'h44;
    bd[0] = 32'hCAFEF00D; bd[1] = 32'h0BADC0DE; bd[2] = 32'h0; bd[3] = 32'h0;
    bw[0] = 1; bw[1] = 1; bw[2] = 0; bw[3] = 0;
    for (int i = 0; i < 4; i++) brd[i] = '0;
    n = 0; pulses = 0; last = -1; cycn = 0; gap_bad = 0;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = bw[0]; req_addr[d] = ba[0];
    req_wdata[d] = bd[0]; req_be[d] = 4'hF;
    for (int k = 0; k < 60 && pulses < 4; k++) begin
      @(negedge clk);
      cycn++;
      if (rsp_valid[d]) begin
        if (last >= 0 && cycn - last != ws_of(d) + 2) gap_bad++;
        last = cycn;
        brd[pulses] = rsp_rdata[d];
        pulses++;
      end
      acc = req_valid[d] && req_ready[d];
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n == 4) idle_junk(d);
        else begin
          req_write[d] = bw[n]; req_addr[d] = ba[n]; req_wdata[d] = bd[n]; req_be[d] = 4'hF;
        end
      end
    end
    for (int k = 0; k < ws_of(d) + 4; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) pulses++;
    end
    chk("burst_accepts", d, 32'(n), 32'd4);
    chk("burst_pulses",  d, 32'(pulses), 32'd4);
    chk("burst_spacing", d, 32'(gap_bad), 32'd0);
    chk("burst_load0",   d, brd[2], 32'hCAFEF00D);
    chk("burst_load1",   d, brd[3], 32'h0BADC0DE);
  endtask

  task automatic reset_test(input int d);
    logic [31:0] rd; logic e; int lat; int pulses; bit got;
    do_req(d, 1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
    chk("rst_prestore_err", d, 32'(e), 32'd0);
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'h20;
    req_wdata[d] = 32'h55AA55AA; req_be[d] = 4'hF;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[d]) got = 1;
    end
    chk("rst_accept", d, 32'(got), 32'd1);
    @(posedge clk); #1;
    idle_junk(d);
    reset_n[d] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) pulses++;
    end
    @(posedge clk); #1;
    reset_n[d] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) pulses++;
    end
    chk("rst_no_rsp", d, 32'(pulses), 32'd0);
    do_req(d, 0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    chk("rst_load_old", d, rd, 32'h11223344);
    chk("rst_load_err", d, 32'(e), 32'd0);
  endtask

  task automatic run_suite(input int d);
    logic [31:0] rd; logic e; int lat; int r;
    logic [31:0] a;
    int exp_lat;
    exp_lat = (d == 0) ? 3 : 1;

    for (int i = 0; i < 256; i++)
      do_req(d, 1, 32'(i * 4), (i == 0) ? 32'h01234567 : $urandom, 4'hF, rd, e, lat);

    do_req(d, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    chk("st_err", d, 32'(e), 32'd0);
    chk("st_rdata", d, rd, 32'd0);
    chk("st_latency", d, 32'(lat), 32'(exp_lat));
    do_req(d, 0, 32'h10, $urandom, 4'($urandom), rd, e, lat);
    chk("ld_rdata", d, rd, 32'hDEADBEEF);
    chk("ld_err", d, 32'(e), 32'd0);
    chk("ld_latency", d, 32'(lat), 32'(exp_lat));

    do_req(d, 1, 32'h10, 32'h0000AA00, 4'b0010, rd, e, lat);
    do_req(d, 0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("partial_rdata", d, rd, 32'hDEADAAEF);

    do_req(d, 0, 32'h13, 32'h0, 4'h0, rd, e, lat);
    chk("misalign_err", d, 32'(e), 32'd1);
    chk("misalign_rdata", d, rd, 32'd0);

    do_req(d, 1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    chk("oor_err", d, 32'(e), 32'd1);
    do_req(d, 0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    chk("word0_unchanged", d, rd, 32'h01234567);
    chk("word0_err", d, 32'(e), 32'd0);

    do_req(d, 1, 32'h10, 32'h12345678, 4'b0000, rd, e, lat);
    chk("be0_err", d, 32'(e), 32'd0);
    do_req(d, 0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("be0_noop", d, rd, 32'hDEADAAEF);

    burst(d);
    if (ws_of(d) > 0) reset_test(d);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h400 + ($urandom & 32'h0000_FFFC);
      else             a = $urandom & 32'h3FC;
      do_req(d, 1'($urandom), a, $urandom, 4'($urandom), rd, e, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0;
      idle_junk(d);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, 32'(req_ready[d]), 32'd1);
      chk("reset_valid", d, 32'(rsp_valid[d]), 32'd0);
      chk("reset_rdata", d, rsp_rdata[d], 32'd0);
      chk("reset_err",   d, 32'(rsp_err[d]), 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) reset_n[d] = 1'b1;
    for (int d = 0; d < 2; d++) run_suite(d);
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
